// File: rtl/lbp_img_server.sv
`default_nettype none
// ============================================================================
//  Module   : lbp_img_server
//  Purpose  : Memory-side responder for an LBP engine. Loads a gray image from
//             an upstream byte stream, serves zero-latency pixel reads, captures
//             LBP result writes and streams the result image out once the
//             engine signals finish.
//  Ports    : clk_i, reset_ni          - clock, asynchronous active-low reset
//             start_i                  - begin a new session (IDLE/DONE only)
//             load_valid_i/_data_i, load_ready_o - upstream pixel stream
//             gray_ready_o, gray_req_i, gray_addr_i, gray_data_o - read port
//             lbp_valid_i, lbp_addr_i, lbp_data_i - result write port
//             finish_i                 - engine done (level)
//             res_valid_o/_addr_o/_data_o, res_ready_i - result stream
//             done_o                   - session complete, held until start
//  Revision : 1.0 - initial release
// ============================================================================
module lbp_img_server #(
  parameter int ADDR_W = 14,
  parameter int PIX_W  = 8
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              start_i,
  input  logic              load_valid_i,
  input  logic [PIX_W-1:0]  load_data_i,
  output logic              load_ready_o,
  output logic              gray_ready_o,
  input  logic              gray_req_i,
  input  logic [ADDR_W-1:0] gray_addr_i,
  output logic [PIX_W-1:0]  gray_data_o,
  input  logic              lbp_valid_i,
  input  logic [ADDR_W-1:0] lbp_addr_i,
  input  logic [PIX_W-1:0]  lbp_data_i,
  input  logic              finish_i,
  output logic              res_valid_o,
  output logic [ADDR_W-1:0] res_addr_o,
  output logic [PIX_W-1:0]  res_data_o,
  input  logic              res_ready_i,
  output logic              done_o
);

  localparam int              DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SERVE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ld_cnt_q, ld_cnt_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;

  logic [PIX_W-1:0]  gray_mem [DEPTH];
  logic [PIX_W-1:0]  lbp_mem  [DEPTH];

  logic w_ld_we;
  logic w_lbp_we;

  assign w_ld_we  = (state_q == S_LOAD)  && load_valid_i;
  assign w_lbp_we = (state_q == S_SERVE) && lbp_valid_i;

  // Every load beat also clears the matching result location, so addresses the
  // engine never writes drain out as zero without a separate clear pass.
  // Writes in SERVE include the cycle where finish rises, so that write lands
  // before the first drain beat is read.
  always_ff @(posedge clk_i) begin
    if (w_ld_we) begin
      gray_mem[ld_cnt_q] <= load_data_i;
      lbp_mem[ld_cnt_q]  <= '0;
    end else if (w_lbp_we) begin
      lbp_mem[lbp_addr_i] <= lbp_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= S_IDLE;
      ld_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ld_cnt_d     = ld_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    load_ready_o = 1'b0;
    gray_ready_o = 1'b0;
    gray_data_o  = '0;
    res_valid_o  = 1'b0;
    res_addr_o   = '0;
    res_data_o   = '0;
    done_o       = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        done_o = (state_q == S_DONE);
        if (start_i) begin
          state_d  = S_LOAD;
          ld_cnt_d = '0;
          rd_cnt_d = '0;
        end
      end

      S_LOAD: begin
        load_ready_o = 1'b1;
        if (load_valid_i) begin
          // Terminal beat moves on instead of wrapping the counter.
          if (ld_cnt_q == LAST) begin
            state_d  = S_SERVE;
            ld_cnt_d = '0;
          end else begin
            ld_cnt_d = ld_cnt_q + 1'b1;
          end
        end
      end

      S_SERVE: begin
        gray_ready_o = 1'b1;
        // The engine samples on the next edge, so data must be combinational.
        if (gray_req_i) begin
          gray_data_o = gray_mem[gray_addr_i];
        end
        if (finish_i) begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        res_valid_o = 1'b1;
        res_addr_o  = rd_cnt_q;
        res_data_o  = lbp_mem[rd_cnt_q];
        if (res_ready_i) begin
          if (rd_cnt_q == LAST) begin
            state_d  = S_DONE;
            rd_cnt_d = '0;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_lbp_img_server.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lbp_img_server
//  Purpose  : Self-checking bench for lbp_img_server. Result beats are checked
//             by a monitor against an expected-beat queue filled by stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lbp_img_server;

  localparam int ADDR_W = 14;
  localparam int PIX_W  = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              load_valid;
  logic [PIX_W-1:0]  load_data;
  logic              load_ready;
  logic              gray_ready;
  logic              gray_req;
  logic [ADDR_W-1:0] gray_addr;
  logic [PIX_W-1:0]  gray_data;
  logic              lbp_valid;
  logic [ADDR_W-1:0] lbp_addr;
  logic [PIX_W-1:0]  lbp_data;
  logic              finish;
  logic              res_valid;
  logic [ADDR_W-1:0] res_addr;
  logic [PIX_W-1:0]  res_data;
  logic              res_ready;
  logic              done;

  always #5 clk = ~clk;

  lbp_img_server #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) dut (
    .clk_i        (clk),
    .reset_ni     (rst_n),
    .start_i      (start),
    .load_valid_i (load_valid),
    .load_data_i  (load_data),
    .load_ready_o (load_ready),
    .gray_ready_o (gray_ready),
    .gray_req_i   (gray_req),
    .gray_addr_i  (gray_addr),
    .gray_data_o  (gray_data),
    .lbp_valid_i  (lbp_valid),
    .lbp_addr_i   (lbp_addr),
    .lbp_data_i   (lbp_data),
    .finish_i     (finish),
    .res_valid_o  (res_valid),
    .res_addr_o   (res_addr),
    .res_data_o   (res_data),
    .res_ready_i  (res_ready),
    .done_o       (done)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [PIX_W-1:0]  d;
  } beat_t;

  beat_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compares every accepted result beat against the queue, and
  // checks that a stalled beat holds its address and data.
  logic              stall_pend = 1'b0;
  logic [ADDR_W-1:0] stall_a;
  logic [PIX_W-1:0]  stall_d;

  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      if (stall_pend) begin
        chk("hold_addr", 32'(res_addr), 32'(stall_a));
        chk("hold_data", 32'(res_data), 32'(stall_d));
      end
      if (res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual_addr=%0h required=none", res_addr);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("res_addr", 32'(res_addr), 32'(e.a));
          chk("res_data", 32'(res_data), 32'(e.d));
        end
        stall_pend <= 1'b0;
      end else begin
        stall_pend <= 1'b1;
        stall_a    <= res_addr;
        stall_d    <= res_data;
      end
    end else begin
      stall_pend <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full-image load; pat=1 loads the inverted ramp. A stray lbp write to an
  // already-cleared address is issued mid-load and must have no effect.
  task automatic load_image(input bit pat);
    int         acc;
    int         rdy_bad;
    logic [7:0] v;
    acc     = 0;
    rdy_bad = 0;
    load_valid = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      v = k[7:0];
      load_data = pat ? ~v : v;
      if (k == 200) begin
        lbp_valid = 1'b1;
        lbp_addr  = 14'h0010;
        lbp_data  = 8'hEE;
      end else begin
        lbp_valid = 1'b0;
      end
      @(negedge clk);
      if (load_ready) acc++;
      if (gray_ready) rdy_bad++;
      @(posedge clk);
      #1;
    end
    load_valid = 1'b0;
    lbp_valid  = 1'b0;
    chk("load_beats", 32'(acc), 32'(DEPTH));
    chk("gray_ready_during_load", 32'(rdy_bad), 32'd0);
    chk("load_ready_after_load", 32'(load_ready), 32'd0);
    chk("gray_ready_after_load", 32'(gray_ready), 32'd1);
  endtask

  task automatic drain(input bit toggle);
    int cyc;
    cyc = 0;
    while (!done && cyc < 40000) begin
      res_ready = toggle ? (((cyc / 3) % 2) == 0) : 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    res_ready = 1'b0;
    chk("drain_done", 32'(done), 32'd1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("res_valid_in_done", 32'(res_valid), 32'd0);
  endtask

  initial begin
    int bad;
    rst_n      = 1'b1;
    start      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    gray_req   = 1'b0;
    gray_addr  = '0;
    lbp_valid  = 1'b0;
    lbp_addr   = '0;
    lbp_data   = '0;
    finish     = 1'b0;
    res_ready  = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) tick();

    chk("rst_load_ready", 32'(load_ready), 32'd0);
    chk("rst_gray_ready", 32'(gray_ready), 32'd0);
    chk("rst_res_valid",  32'(res_valid),  32'd0);
    chk("rst_res_addr",   32'(res_addr),   32'd0);
    chk("rst_done",       32'(done),       32'd0);
    rst_n = 1'b1;
    tick();

    // Aborted session: reset lands after 100 beats.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_ready_in_load", 32'(load_ready), 32'd1);
    load_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      load_data = 8'h55;
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("abort_load_ready", 32'(load_ready), 32'd0);
    chk("abort_gray_ready", 32'(gray_ready), 32'd0);
    chk("abort_res_valid",  32'(res_valid),  32'd0);
    chk("abort_done",       32'(done),       32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (load_ready || gray_ready) bad++;
      @(posedge clk);
      #1;
    end
    load_valid = 1'b0;
    chk("idle_ignores_load", 32'(bad), 32'd0);

    // Session 1: ramp image.
    start = 1'b1;
    tick();
    start = 1'b0;
    load_image(1'b0);

    gray_req  = 1'b1;
    gray_addr = 14'h0081;
    #1 chk("gray_0081", 32'(gray_data), 32'h81);
    gray_addr = 14'h0000;
    #1 chk("gray_0000", 32'(gray_data), 32'h00);
    gray_addr = 14'h3FFF;
    #1 chk("gray_3fff", 32'(gray_data), 32'hFF);
    gray_addr = 14'h0064;
    #1 chk("gray_0064_reloaded", 32'(gray_data), 32'h64);
    gray_req  = 1'b0;
    #1 chk("gray_no_req", 32'(gray_data), 32'h00);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_ignored_serve", 32'(gray_ready), 32'd1);

    for (int i = 0; i < DEPTH; i++) begin
      beat_t e;
      e.a = ADDR_W'(i);
      e.d = (i == 'h81) ? 8'h5A : (i == 'h82) ? 8'h3C : 8'h00;
      exp_q.push_back(e);
    end
    lbp_valid = 1'b1;
    lbp_addr  = 14'h0081; lbp_data = 8'hA5;
    tick();
    lbp_addr  = 14'h0082; lbp_data = 8'h3C;
    tick();
    lbp_addr  = 14'h0081; lbp_data = 8'h5A;
    finish    = 1'b1;
    tick();
    lbp_valid = 1'b0;
    chk("drain_entered", 32'(res_valid), 32'd1);
    drain(1'b1);
    finish = 1'b0;

    // Writes while DONE must be ignored.
    lbp_valid = 1'b1;
    lbp_addr  = 14'h0020;
    lbp_data  = 8'h77;
    tick();
    tick();
    lbp_valid = 1'b0;
    chk("done_held", 32'(done), 32'd1);

    // Session 2: inverted ramp, no engine writes; result must be all zero.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_cleared_by_start", 32'(done), 32'd0);
    load_image(1'b1);
    gray_req  = 1'b1;
    gray_addr = 14'h0081;
    #1 chk("gray2_0081", 32'(gray_data), 32'h7E);
    gray_req  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      beat_t e;
      e.a = ADDR_W'(i);
      e.d = 8'h00;
      exp_q.push_back(e);
    end
    finish = 1'b1;
    tick();
    drain(1'b0);
    finish = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
